// File: rtl/hack_reg_arbiter.sv
// hack_reg_arbiter: round-robin write arbiter driving a shared register of hack_bit cells.
// Tracks the last writer, a wrapping write count and a one-cycle grant acknowledge.
module hack_bit (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic load,
    output logic out
);
    logic bit_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) bit_q <= 1'b0;
        else if (load) bit_q <= in;
    assign out = bit_q;
endmodule

module hack_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      reg_out,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    output logic [7:0]            wr_count
);
    logic [NREQ-1:0]  gnt_q, gnt_d, elig;
    logic [IDW-1:0]   owner_q, owner_d, ptr_q, ptr_d, win;
    logic [7:0]       wr_count_q, wr_count_d;
    logic             busy_q, busy_d, found;
    logic [WIDTH-1:0] din;
    int               idx;

    // a requester being acknowledged this cycle is masked so a held req cannot double-write
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        gnt_d      = found ? NREQ'(1) << win : '0;
        owner_d    = found ? win : owner_q;
        busy_d     = found;
        wr_count_d = wr_count_q + {7'd0, found};
        ptr_d      = found ? (win == IDW'(NREQ - 1) ? '0 : win + 1'b1) : ptr_q;
        din        = found ? wdata[win*WIDTH +: WIDTH] : reg_out;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            wr_count_q <= '0;
        end else begin
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            wr_count_q <= wr_count_d;
        end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        hack_bit u_bit (.clk(clk), .reset(reset), .in(din[b]), .load(found), .out(reg_out[b]));
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_hack_reg_arbiter.sv
// tb_hack_reg_arbiter: scoreboard bench; a rotation-based reference model predicts each cycle's outputs.
module tb_hack_reg_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]  gnt;
    logic [W-1:0]  reg_out;
    logic [1:0]    owner;
    logic          busy;
    logic [7:0]    wr_count;

    hack_reg_arbiter #(.NREQ(N), .WIDTH(W), .IDW(2)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt),
        .reg_out(reg_out), .owner(owner), .busy(busy), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] r;
        logic [1:0]   own;
        logic [7:0]   cnt;
        logic         busy;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int m_reg, m_owner, m_cnt, m_ptr, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_reg = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_last = -1;
    endfunction

    // rotate starting at the pointer; the requester acknowledged last cycle sits this one out
    function automatic void model_step(input logic [N-1:0] r, input logic [N*W-1:0] wd);
        int w;
        int i;
        exp_t e;
        w = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (w < 0 && r[i] && i != m_last) w = i;
        end
        if (w >= 0) begin
            m_reg   = int'(wd[w*W +: W]);
            m_owner = w;
            m_cnt   = (m_cnt + 1) % 256;
            m_ptr   = (w + 1) % N;
        end
        m_last = w;
        e.gnt  = (w >= 0) ? N'(1 << w) : '0;
        e.r    = W'(m_reg);
        e.own  = 2'(m_owner);
        e.cnt  = 8'(m_cnt);
        e.busy = (w >= 0);
        q.push_back(e);
    endfunction

    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] wd);
        @(negedge clk);
        req   = r;
        wdata = wd;
        model_step(r, wd);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("reg_out", 32'(reg_out), 32'(e.r));
                chk("owner", 32'(owner), 32'(e.own));
                chk("wr_count", 32'(wr_count), 32'(e.cnt));
                chk("busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    initial begin : driver
        logic [N*W-1:0] d;
        logic [7:0] cnt0;
        model_reset();
        #1;
        chk("rst_reg_out", 32'(reg_out), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        d = '0; d[47:32] = 16'hBEEF;
        cycle(4'b0100, d);
        settle();
        chk("single_reg", 32'(reg_out), 32'hBEEF);
        chk("single_gnt", 32'(gnt), 32'b0100);
        chk("single_owner", 32'(owner), 2);
        chk("single_cnt", 32'(wr_count), 1);
        cycle(4'b0100, d);
        settle();
        chk("held_masked_gnt", 32'(gnt), 0);
        d[47:32] = 16'h1234;
        cycle(4'b0100, d);
        settle();
        chk("rewrite_reg", 32'(reg_out), 32'h1234);

        d = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        cycle(4'b1000, d);
        cycle(4'b0000, d);
        cycle(4'b1111, d);
        cycle(4'b1110, d);
        cycle(4'b1100, d);
        cycle(4'b1000, d);
        cycle(4'b0000, d);
        settle();
        chk("contention_reg", 32'(reg_out), 32'h3);
        chk("contention_owner", 32'(owner), 3);

        d = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        cycle(4'b1010, d);
        settle();
        chk("rr_first_1", 32'(owner), 1);
        cycle(4'b1010, d);
        settle();
        chk("rr_then_3", 32'(owner), 3);
        cycle(4'b1001, d);
        settle();
        chk("rr_wrap_0", 32'(owner), 0);
        cycle(4'b1001, d);
        settle();
        chk("rr_then_3b", 32'(owner), 3);
        cycle(4'b0000, d);

        cnt0 = wr_count;
        d = {16'hAAAA, 16'hBBBB, 16'h5151, 16'h7070};
        cycle(4'b0011, d);
        cycle(4'b0000, d);
        cycle(4'b0000, d);
        settle();
        chk("withdraw_reg", 32'(reg_out), 32'h7070);
        chk("withdraw_cnt", 32'(wr_count), 32'(8'(cnt0 + 8'd1)));

        repeat (300) begin
            cycle(N'($urandom_range(0, 15)), {$urandom, $urandom});
        end
        cycle(4'b0000, d);

        cycle(4'b1111, d);
        cycle(4'b1111, d);
        @(posedge clk);
        #3;
        reset = 1'b1;
        req = '0;
        #1;
        chk("midrst_reg_out", 32'(reg_out), 0);
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_owner", 32'(owner), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wr_count", 32'(wr_count), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(4'b1111, d);
        settle();
        chk("postrst_gnt", 32'(gnt), 32'b0001);
        chk("postrst_owner", 32'(owner), 0);

        for (int i = 1; i < 256; i++) begin
            d = '0;
            d[31:16] = 16'(i * 7 + 3);
            cycle(4'b0010, d);
            cycle(4'b0000, d);
        end
        settle();
        chk("wrap_cnt", 32'(wr_count), 0);
        chk("wrap_owner", 32'(owner), 1);
        chk("wrap_reg", 32'(reg_out), 32'(16'(255 * 7 + 3)));

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hack_reg_arbiter.md
Name: hack_reg_arbiter

Overview:
- Round-robin write arbiter for one shared WIDTH-bit Hack register built from hack_bit cells (in/load/out per bit).
- NREQ requesters each present a request and a data word.
- The arbiter selects at most one winner per clock and drives the register's in/load, so the write lands on that edge.
- It returns a one-cycle grant acknowledgement, and owns the register value and the last-writer identity for downstream readers.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 16, register data width (Hack word)
IDW, 2, width of owner index; must equal ceil(log2(NREQ))

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
req  input  NREQ  per-requester write request, level, bit i = requester i
wdata  input  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot acknowledge: bit i high for exactly one cycle after requester i's data was written
reg_out  output  WIDTH  current shared register contents (hack_bit out vector)
owner  output  IDW  index of requester that performed the most recent write
busy  output  1  registered; high in any cycle following a write (== |gnt)
wr_count  output  8  number of completed writes, wraps 255->0

Behaviour:
- Reset (asynchronous, while high):
  - reg_out=0, gnt=0, owner=0, busy=0, wr_count=0.
  - Priority pointer ptr=0.
  - Reset mid-operation discards any in-flight grant. No gnt appears after reset releases unless re-arbitrated.
- Eligible set each cycle: elig[i] = req[i] & ~gnt[i].
  - A requester currently being acknowledged is masked for that cycle.
  - This prevents a double write when it has not yet dropped req.
- Winner selection (combinational):
  - Scan elig starting at index ptr, then ptr+1 ... wrapping mod NREQ.
  - The first set bit wins. If elig==0, there is no winner.
- Write (on the rising edge, when a winner w exists):
  - reg_out <= wdata[w].
  - Register load=1 for every bit; in = wdata[w].
  - gnt <= one-hot(w); owner <= w; busy <= 1.
  - wr_count <= wr_count+1 (8-bit wrap).
  - ptr <= (w+1) mod NREQ.
- No winner:
  - gnt <= 0; busy <= 0.
  - reg_out, owner, ptr, wr_count hold. Register load=0.
- Latency:
  - Data is visible on reg_out one edge after the cycle in which req was sampled with the requester eligible and winning.
  - gnt rises in that same cycle.
- Requester protocol:
  - Hold req and wdata stable until gnt seen high.
  - In the gnt cycle the requester may drop req, or keep it high with new wdata for a back-to-back write. The back-to-back write is eligible no earlier than the following cycle.
  - Dropping req before gnt withdraws the request with no write.
- Throughput:
  - One write per cycle overall.
  - A single requester alone can write at most every other cycle because of the gnt mask.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,...,NREQ-1,0; none waits more than NREQ-1 writes.
- wdata of non-winning requesters is ignored. X on unrequested wdata must not propagate to reg_out.
- Two consecutive writes by the same requester are allowed only when no other requester is eligible.

Test Plan:
- Reset: assert reset mid-cycle with req=4'b1111 -> reg_out=0, gnt=0, owner=0, wr_count=0 immediately; after release, first write comes from requester 0.
- Single request: req=4'b0100, wdata[2]=16'hBEEF -> next edge reg_out=BEEF, gnt=4'b0100 for one cycle, owner=2, wr_count=1. With req held high: gnt=0 on the following edge, then a rewrite on the edge after.
- Full contention: req=4'b1111, data words 0x0000..0x0003 by index, each requester drops req on its gnt -> writes in order 0,1,2,3 on four consecutive edges; reg_out ends 0x0003; gnt never has two bits set.
- Round-robin wrap: after a grant to 3 (ptr=0), req=4'b1010 -> grant 1 then 3; next req=4'b1001 -> grant 0 then 3.
- Withdraw: req[1] pulsed for one cycle while requester 0 wins that cycle -> no write from 1, reg_out unchanged, wr_count increments only once.
- Counter wrap: 256 single-requester writes -> wr_count returns to 0, owner and reg_out match the last write.
